// File: rtl/bus_initiator_if.sv
// MemoryBus: initiator/target link between a bus master and slave register files.
// Master drives msValid/msAddress/msWrite/msData/msID and smTaken; it samples
// msTaken and the response channel smValid/smData/smID. Slave is the mirror.
interface MemoryBus #(
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ID_WIDTH      = 4
);
    logic                     msValid;
    logic [ADDRESS_WIDTH-1:0] msAddress;
    logic                     msWrite;
    logic [DATA_WIDTH-1:0]    msData;
    logic [ID_WIDTH-1:0]      msID;
    logic                     msTaken;

    logic                     smValid;
    logic [DATA_WIDTH-1:0]    smData;
    logic [ID_WIDTH-1:0]      smID;
    logic                     smTaken;

    modport Master (
        output msValid, msAddress, msWrite, msData, msID, smTaken,
        input  msTaken, smValid, smData, smID
    );

    modport Slave (
        input  msValid, msAddress, msWrite, msData, msID, smTaken,
        output msTaken, smValid, smData, smID
    );
endinterface

// File: rtl/bus_initiator.sv
// bus_initiator: converts a command stream into MemoryBus master transactions.
// Writes are posted; reads carry a rolling ID and consume a credit that is only
// returned when the read response is popped, so the response FIFO never overflows.
// Ports:
//   clock, reset            clock and asynchronous active-low reset
//   cmdValid/cmdReady       command handshake (cmdWrite, cmdAddress, cmdData)
//   rspValid/rspReady       read response handshake (rspData, rspID)
//   idle                    no request held and no credits in use
//   error                   sticky: a response arrived that no credit accounts for
//   bus                     MemoryBus master side
module bus_initiator #(
    parameter int unsigned DATA_WIDTH      = 24,
    parameter int unsigned ADDRESS_WIDTH   = 32,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic                     cmdWrite,
    input  logic [ADDRESS_WIDTH-1:0] cmdAddress,
    input  logic [DATA_WIDTH-1:0]    cmdData,
    output logic                     rspValid,
    input  logic                     rspReady,
    output logic [DATA_WIDTH-1:0]    rspData,
    output logic [ID_WIDTH-1:0]      rspID,
    output logic                     idle,
    output logic                     error,
    MemoryBus.Master                 bus
);

    localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int          DEPTH = int'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MAX_CRED = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } rsp_t;

    logic              reqValid;
    logic [ID_WIDTH-1:0] nextID;
    logic [CW-1:0]     credits;
    logic [CW-1:0]     fifoCount;
    logic [CW-1:0]     wrIdx;
    rsp_t              fifoMem [DEPTH];
    rsp_t              pushEntry;

    logic entryFree;
    logic accept;
    logic acceptRead;
    logic fifoFull;
    logic capture;
    logic push;
    logic pop;
    logic stray;

    // Handshake decode; the entry frees combinationally on a taken cycle so
    // back-to-back commands sustain one per cycle.
    assign entryFree  = !reqValid || bus.msTaken;
    assign cmdReady   = entryFree && (cmdWrite || (credits < MAX_CRED));
    assign accept     = cmdValid && cmdReady;
    assign acceptRead = accept && !cmdWrite;

    assign fifoFull    = (fifoCount == MAX_CRED);
    assign bus.smTaken = !fifoFull;
    assign capture     = bus.smValid && !fifoFull;
    // A response is legitimate only if some credit is not already backed by a FIFO entry.
    assign push        = capture && (credits > fifoCount);
    assign stray       = capture && !(credits > fifoCount);

    assign rspValid  = (fifoCount != '0);
    assign pop       = rspValid && rspReady;
    assign rspData   = fifoMem[0].data;
    assign rspID     = fifoMem[0].id;
    assign pushEntry = '{data: bus.smData, id: bus.smID};
    assign wrIdx     = pop ? (fifoCount - CW'(1)) : fifoCount;

    assign bus.msValid = reqValid;
    assign idle        = !reqValid && (credits == '0);

    // Request register and rolling read ID.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reqValid      <= 1'b0;
            bus.msAddress <= '0;
            bus.msWrite   <= 1'b0;
            bus.msData    <= '0;
            bus.msID      <= '0;
            nextID        <= '0;
        end else begin
            if (accept) begin
                reqValid      <= 1'b1;
                bus.msAddress <= cmdAddress;
                bus.msWrite   <= cmdWrite;
                bus.msData    <= cmdWrite ? cmdData : '0;
                bus.msID      <= nextID;
            end else if (bus.msTaken) begin
                reqValid <= 1'b0;
            end
            if (acceptRead) begin
                nextID <= nextID + ID_WIDTH'(1);
            end
        end
    end

    // Read credits: taken on read accept, returned on response pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits <= '0;
        end else begin
            case ({acceptRead, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Sticky stray-response flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (stray) begin
            error <= 1'b1;
        end
    end

    // Shifting response FIFO: entry 0 is always the head, so rspData/rspID come straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifoCount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifoMem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (CW'(i) == wrIdx)) begin
                    fifoMem[i] <= pushEntry;
                end else if (pop && (i < DEPTH - 1)) begin
                    fifoMem[i] <= fifoMem[(i + 1) % DEPTH];
                end
            end
            fifoCount <= fifoCount + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Testbench for bus_initiator: a cycle table for write-then-read, then directed
// sequences for credit stall, write bypass, ID wrap, backpressure, stray and reset.
module tb_bus_initiator;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clock;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [31:0] cmdAddress;
    logic [23:0] cmdData;
    logic        rspValid;
    logic        rspReady;
    logic [23:0] rspData;
    logic [3:0]  rspID;
    logic        idle;
    logic        error;

    int n_run;
    int n_fail;

    MemoryBus #(.DATA_WIDTH(24), .ADDRESS_WIDTH(32), .ID_WIDTH(4)) bus ();

    bus_initiator #(
        .DATA_WIDTH(24), .ADDRESS_WIDTH(32), .ID_WIDTH(4), .MAX_OUTSTANDING(4)
    ) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddress(cmdAddress), .cmdData(cmdData),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspID(rspID),
        .idle(idle), .error(error),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        cv;
        logic        cw;
        logic [31:0] ca;
        logic [23:0] cd;
        logic        mt;
        logic        sv;
        logic [23:0] sd;
        logic [3:0]  sid;
        logic        rr;
        logic        e_cr;
        logic        e_mv;
        logic        e_mw;
        logic [3:0]  e_mid;
        logic [31:0] e_ma;
        logic [23:0] e_md;
        logic        e_st;
        logic        e_rv;
        logic [23:0] e_rd;
        logic [3:0]  e_rid;
        logic        e_idle;
        logic        e_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge, then settle.
    task automatic drive(input logic cv, input logic cw, input logic [31:0] ca, input logic [23:0] cd,
                         input logic mt, input logic sv, input logic [23:0] sd, input logic [3:0] sid,
                         input logic rr);
        cmdValid    = cv;
        cmdWrite    = cw;
        cmdAddress  = ca;
        cmdData     = cd;
        bus.msTaken = mt;
        bus.smValid = sv;
        bus.smData  = sd;
        bus.smID    = sid;
        rspReady    = rr;
        #1;
    endtask

    task automatic do_reset();
        drive(L, L, 32'h0, 24'h0, L, L, 24'h0, 4'h0, L);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, run=%0d failed=%0d", n_run, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b0;
        drive(L, L, 32'h0, 24'h0, L, L, 24'h0, 4'h0, L);

        // Reset state
        @(negedge clock);
        #1;
        chk("rst_msValid",   64'(bus.msValid),   64'(0));
        chk("rst_msAddress", 64'(bus.msAddress), 64'(0));
        chk("rst_msData",    64'(bus.msData),    64'(0));
        chk("rst_msID",      64'(bus.msID),      64'(0));
        chk("rst_msWrite",   64'(bus.msWrite),   64'(0));
        chk("rst_rspValid",  64'(rspValid),      64'(0));
        chk("rst_error",     64'(error),         64'(0));
        chk("rst_idle",      64'(idle),          64'(1));
        reset = 1'b1;
        @(negedge clock);

        // Write 0x001234 to 0x04, then read 0x04; slave always takes.
        //           cv cw ca      cd          mt sv sd          sid  rr  cr mv mw mid   ma      md          st rv rd          rid  idle err
        vecs[0] = '{H, H, 32'h4, 24'h001234, H, L, 24'h0,      4'h0, L, H, L, L, 4'h0, 32'h0, 24'h0,      H, L, 24'h0,      4'h0, H, L};
        vecs[1] = '{H, L, 32'h4, 24'h0,      H, L, 24'h0,      4'h0, L, H, H, H, 4'h0, 32'h4, 24'h001234, H, L, 24'h0,      4'h0, L, L};
        vecs[2] = '{L, L, 32'h0, 24'h0,      H, L, 24'h0,      4'h0, L, H, H, L, 4'h0, 32'h4, 24'h0,      H, L, 24'h0,      4'h0, L, L};
        vecs[3] = '{L, L, 32'h0, 24'h0,      H, H, 24'h001234, 4'h0, L, H, L, L, 4'h0, 32'h0, 24'h0,      H, L, 24'h0,      4'h0, L, L};
        vecs[4] = '{L, L, 32'h0, 24'h0,      H, L, 24'h0,      4'h0, H, H, L, L, 4'h0, 32'h0, 24'h0,      H, H, 24'h001234, 4'h0, L, L};
        vecs[5] = '{L, L, 32'h0, 24'h0,      H, L, 24'h0,      4'h0, L, H, L, L, 4'h0, 32'h0, 24'h0,      H, L, 24'h0,      4'h0, H, L};

        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].cv, vecs[v].cw, vecs[v].ca, vecs[v].cd, vecs[v].mt,
                  vecs[v].sv, vecs[v].sd, vecs[v].sid, vecs[v].rr);
            chk($sformatf("wr_rd[%0d].cmdReady", v), 64'(cmdReady),    64'(vecs[v].e_cr));
            chk($sformatf("wr_rd[%0d].msValid", v),  64'(bus.msValid), 64'(vecs[v].e_mv));
            if (vecs[v].e_mv) begin
                chk($sformatf("wr_rd[%0d].msWrite", v),   64'(bus.msWrite),   64'(vecs[v].e_mw));
                chk($sformatf("wr_rd[%0d].msID", v),      64'(bus.msID),      64'(vecs[v].e_mid));
                chk($sformatf("wr_rd[%0d].msAddress", v), 64'(bus.msAddress), 64'(vecs[v].e_ma));
                chk($sformatf("wr_rd[%0d].msData", v),    64'(bus.msData),    64'(vecs[v].e_md));
            end
            chk($sformatf("wr_rd[%0d].smTaken", v),  64'(bus.smTaken), 64'(vecs[v].e_st));
            chk($sformatf("wr_rd[%0d].rspValid", v), 64'(rspValid),    64'(vecs[v].e_rv));
            if (vecs[v].e_rv) begin
                chk($sformatf("wr_rd[%0d].rspData", v), 64'(rspData), 64'(vecs[v].e_rd));
                chk($sformatf("wr_rd[%0d].rspID", v),   64'(rspID),   64'(vecs[v].e_rid));
            end
            chk($sformatf("wr_rd[%0d].idle", v),  64'(idle),  64'(vecs[v].e_idle));
            chk($sformatf("wr_rd[%0d].error", v), 64'(error), 64'(vecs[v].e_err));
            @(negedge clock);
        end

        // Credit stall with rspReady low, then write bypass, then one pop frees a credit.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(H, L, 32'(k * 4), 24'h0, H, L, 24'h0, 4'h0, L);
            chk("stall_accept", 64'(cmdReady), 64'(1));
            if (k > 0) chk("stall_msID", 64'(bus.msID), 64'(k - 1));
            @(negedge clock);
        end
        drive(H, L, 32'h10, 24'h0, H, L, 24'h0, 4'h0, L);
        chk("stall_5th_blocked", 64'(cmdReady),    64'(0));
        chk("stall_4th_valid",   64'(bus.msValid), 64'(1));
        chk("stall_4th_msID",    64'(bus.msID),    64'(3));
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            drive(H, L, 32'h10, 24'(32'hA0 + k), H, H, 24'(32'hA0 + k), 4'(k), L);
            chk("stall_smTaken",   64'(bus.smTaken), 64'(1));
            chk("stall_blocked_k", 64'(cmdReady),    64'(0));
            @(negedge clock);
        end
        drive(H, H, 32'h40, 24'h005555, H, L, 24'h0, 4'h0, L);
        chk("bypass_write_ready", 64'(cmdReady), 64'(1));
        chk("head_rspValid",      64'(rspValid), 64'(1));
        chk("head_rspData",       64'(rspData),  64'(24'hA0));
        chk("head_rspID",         64'(rspID),    64'(0));
        @(negedge clock);
        drive(H, L, 32'h10, 24'h0, H, L, 24'h0, 4'h0, L);
        chk("bypass_msValid",   64'(bus.msValid),   64'(1));
        chk("bypass_msWrite",   64'(bus.msWrite),   64'(1));
        chk("bypass_msData",    64'(bus.msData),    64'(24'h005555));
        chk("bypass_msAddress", 64'(bus.msAddress), 64'(32'h40));
        chk("bypass_msID",      64'(bus.msID),      64'(4));
        chk("bypass_credits4",  64'(cmdReady),      64'(0));
        chk("head_stable_data", 64'(rspData),       64'(24'hA0));
        @(negedge clock);
        drive(H, L, 32'h10, 24'h0, H, L, 24'h0, 4'h0, H);
        chk("pop_rspValid",      64'(rspValid), 64'(1));
        chk("pop_rspData",       64'(rspData),  64'(24'hA0));
        chk("pop_rspID",         64'(rspID),    64'(0));
        chk("pop_still_blocked", 64'(cmdReady), 64'(0));
        @(negedge clock);
        drive(H, L, 32'h10, 24'h0, H, L, 24'h0, 4'h0, L);
        chk("freed_credit_ready", 64'(cmdReady), 64'(1));
        chk("next_head_data",     64'(rspData),  64'(24'hA1));
        chk("next_head_id",       64'(rspID),    64'(1));
        @(negedge clock);
        drive(L, L, 32'h0, 24'h0, H, L, 24'h0, 4'h0, L);
        chk("fifth_msValid",   64'(bus.msValid),   64'(1));
        chk("fifth_msWrite",   64'(bus.msWrite),   64'(0));
        chk("fifth_msID",      64'(bus.msID),      64'(4));
        chk("fifth_msAddress", 64'(bus.msAddress), 64'(32'h10));
        @(negedge clock);

        // ID wrap: 17 reads, each answered and popped.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(H, L, 32'(i), 24'h0, H, L, 24'h0, 4'h0, L);
            chk("wrap_ready", 64'(cmdReady), 64'(1));
            @(negedge clock);
            drive(L, L, 32'h0, 24'h0, H, L, 24'h0, 4'h0, L);
            chk("wrap_msValid", 64'(bus.msValid), 64'(1));
            chk("wrap_msID",    64'(bus.msID),    64'(i % 16));
            @(negedge clock);
            drive(L, L, 32'h0, 24'h0, H, H, 24'(32'h100 + i), 4'(i % 16), L);
            chk("wrap_smTaken", 64'(bus.smTaken), 64'(1));
            @(negedge clock);
            drive(L, L, 32'h0, 24'h0, H, L, 24'h0, 4'h0, H);
            chk("wrap_rspValid", 64'(rspValid), 64'(1));
            chk("wrap_rspID",    64'(rspID),    64'(i % 16));
            chk("wrap_rspData",  64'(rspData),  64'(24'(32'h100 + i)));
            @(negedge clock);
        end
        drive(L, L, 32'h0, 24'h0, H, L, 24'h0, 4'h0, L);
        chk("wrap_idle",  64'(idle),  64'(1));
        chk("wrap_error", 64'(error), 64'(0));
        @(negedge clock);

        // Backpressure: msTaken low for 3 cycles.
        do_reset();
        drive(H, H, 32'h8, 24'h000ABC, L, L, 24'h0, 4'h0, L);
        chk("bp_first_ready", 64'(cmdReady), 64'(1));
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            drive(H, H, 32'hC, 24'h000DEF, L, L, 24'h0, 4'h0, L);
            chk("bp_msValid",   64'(bus.msValid),   64'(1));
            chk("bp_msAddress", 64'(bus.msAddress), 64'(32'h8));
            chk("bp_msData",    64'(bus.msData),    64'(24'h000ABC));
            chk("bp_msWrite",   64'(bus.msWrite),   64'(1));
            chk("bp_msID",      64'(bus.msID),      64'(0));
            chk("bp_cmdReady",  64'(cmdReady),      64'(0));
            @(negedge clock);
        end
        drive(H, H, 32'hC, 24'h000DEF, H, L, 24'h0, 4'h0, L);
        chk("bp_taken_ready",   64'(cmdReady),      64'(1));
        chk("bp_taken_address", 64'(bus.msAddress), 64'(32'h8));
        @(negedge clock);
        drive(L, L, 32'h0, 24'h0, H, L, 24'h0, 4'h0, L);
        chk("bp_next_msValid",   64'(bus.msValid),   64'(1));
        chk("bp_next_msAddress", 64'(bus.msAddress), 64'(32'hC));
        chk("bp_next_msData",    64'(bus.msData),    64'(24'h000DEF));
        @(negedge clock);

        // Stray response with zero credits, then reset mid-read.
        do_reset();
        drive(L, L, 32'h0, 24'h0, L, H, 24'h00BEEF, 4'h7, L);
        chk("stray_smTaken",   64'(bus.smTaken), 64'(1));
        chk("stray_err_pre",   64'(error),       64'(0));
        @(negedge clock);
        drive(L, L, 32'h0, 24'h0, L, L, 24'h0, 4'h0, L);
        chk("stray_error",     64'(error),    64'(1));
        chk("stray_no_push",   64'(rspValid), 64'(0));
        @(negedge clock);
        drive(H, L, 32'h20, 24'h0, L, L, 24'h0, 4'h0, L);
        chk("stray_error_held", 64'(error),    64'(1));
        chk("midrd_ready",      64'(cmdReady), 64'(1));
        @(negedge clock);
        drive(L, L, 32'h0, 24'h0, L, L, 24'h0, 4'h0, L);
        chk("midrd_msValid", 64'(bus.msValid), 64'(1));
        chk("midrd_idle",    64'(idle),        64'(0));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_msValid", 64'(bus.msValid), 64'(0));
        chk("async_rst_error",   64'(error),       64'(0));
        @(negedge clock);
        reset = 1'b1;
        drive(L, L, 32'h0, 24'h0, L, L, 24'h0, 4'h0, L);
        chk("post_rst_idle",    64'(idle),        64'(1));
        chk("post_rst_msValid", 64'(bus.msValid), 64'(0));
        @(negedge clock);
        drive(L, L, 32'h0, 24'h0, L, H, 24'h000123, 4'h0, L);
        chk("late_rsp_smTaken", 64'(bus.smTaken), 64'(1));
        @(negedge clock);
        drive(L, L, 32'h0, 24'h0, L, L, 24'h0, 4'h0, L);
        chk("late_rsp_error",   64'(error),    64'(1));
        chk("late_rsp_no_push", 64'(rspValid), 64'(0));
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Initiator end of the MemoryBus. The block turns a simple command stream into MemoryBus master transactions that target slave register files such as the ray tracer configuration block. It can come from a UART or host command decoder. Read responses return to the command side through a small buffer. Writes are posted and get no response. Reads are tagged with a rolling ID and are limited by a credit counter, so response data is never dropped.

## Interface
- DATA_WIDTH, 24, width of msData, smData, cmdData, rspData
- ADDRESS_WIDTH, 32, width of msAddress and cmdAddress
- ID_WIDTH, 4, width of msID, smID, rspID
- MAX_OUTSTANDING, 4, read credits; also the depth of the response FIFO (≥1)

Ports:
- clock  in  1  sole clock; all state on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cmdValid  in  1  command present
- cmdReady  out  1  command accepted this cycle when both cmdValid and cmdReady are high
- cmdWrite  in  1  1 = write, 0 = read
- cmdAddress  in  ADDRESS_WIDTH  target address
- cmdData  in  DATA_WIDTH  write data (ignored for reads)
- rspValid  out  1  read response available
- rspReady  in  1  consumer pops the response when both rspValid and rspReady are high
- rspData  out  DATA_WIDTH  read data
- rspID  out  ID_WIDTH  ID of the read
- idle  out  1  no request held and zero credits in use
- error  out  1  sticky; a response arrived with no credit in use
- bus  MemoryBus.Master  drives msValid, msAddress, msWrite, msData, msID and smTaken; samples msTaken, smValid, smData, smID

## Operation
- **Request register.** One entry, reqValid, drives msValid and the ms* fields directly from flops.
  - The entry is free when reqValid=0, or when msValid and msTaken are both high this cycle.
- **Credit counter.** `credits` runs 0..MAX_OUTSTANDING and counts reads accepted but not yet popped from the rsp port.
- **Command acceptance.**
  - cmdReady = entryFree && (cmdWrite || credits < MAX_OUTSTANDING).
  - cmdReady depends on cmdWrite and, combinationally, on msTaken. msValid never depends combinationally on msTaken.
- **On accept:**
  - load msAddress, msWrite and msData (cmdData for writes, 0 for reads);
  - set msID = nextID;
  - for a read only: nextID increments, wrapping mod 2^ID_WIDTH, and credits increments.
- **Issue.** msValid holds with stable fields until msTaken. On a taken cycle with no new accept, reqValid clears.
- **Response capture.**
  - smTaken = !fifoFull.
  - On smValid && smTaken with credits > fifoCount, push {smData, smID}.
  - Otherwise, when credits ≤ fifoCount, the response is stray: it is consumed and dropped, and error is set.
- **Response pop.** On rspValid && rspReady, pop the FIFO and decrement credits.
- **Simultaneous read accept and pop.** credits is unchanged.
- **Overflow guard.** Credits are freed only on pop, so the FIFO cannot overflow while responses are legitimate.
- **Response order.** Responses leave in arrival order. IDs pass through unchanged; the consumer does any reordering.
- **idle** = !reqValid && credits == 0.

## Timing
- **Reset values** (reset low, asynchronous):
  - msValid 0; msAddress, msData, msID and msWrite 0;
  - nextID 0, credits 0, FIFO empty, rspValid 0;
  - error 0, idle 1.
- **Command to bus.** Accept at edge N gives msValid=1 in cycle N+1. Back-to-back commands sustain one per cycle while msTaken stays high.
- **Bus to response.** Capture at edge M gives rspValid=1 from M+1. rspData and rspID are flop outputs.
- **rspValid** holds until popped, and the FIFO head stays stable while rspReady=0.
- **Credits.** A pop at edge P frees a credit, and a read can be accepted in the same cycle P+1 evaluates cmdReady.
- **Reset mid-operation.**
  - Any held request is dropped and msValid falls immediately.
  - Responses that arrive later from the slave are treated as stray and set error.

## Test plan
- **Write then read.** Slave register file at base 0. Write 0x001234 to address 0x04, then read 0x04.
  - Required: one msValid cycle with msWrite=1 and msID=0, then a read with msID=0.
  - Required: rspValid with rspData=0x001234, rspID=0, and idle=1 afterwards.
- **Credit stall.** Hold rspReady=0 and issue 5 reads.
  - Required: the first 4 are accepted with msID 0..3; cmdReady=0 for the 5th.
  - Then one pop is done. Required: the 5th read is accepted and issued with msID=4.
- **Write bypass.** With 4 reads outstanding and unpopped, issue a write.
  - Required: the write is accepted and issued, and credits stay at 4.
- **ID wrap.** Issue 17 sequential reads, each popped.
  - Required: the 17th read has msID=0, and rspID matches msID for every read.
- **Backpressure.** Hold msTaken=0 for 3 cycles after msValid.
  - Required: all ms* fields are stable and cmdReady=0.
  - Required: on the cycle msTaken=1, the next command is accepted.
- **Stray response and reset.** Drive smValid=1 with credits=0.
  - Required: smTaken=1, no push, and error=1 held.
  - Pull reset low mid-read. Required: msValid=0 and error=0 immediately, and idle=1 after release.
